// File: rtl/heap_alloc_pkg.sv
// Shared types and helpers for the heap array allocator.
// Imported by the allocator top and its round-robin arbiter.
package heap_alloc_pkg;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

   localparam logic OP_ALLOC = 1'b0;
   localparam logic OP_FREE  = 1'b1;

   // Index width for an n-entry select, never narrower than one bit
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned NREQ_DEFAULT = 2;
   localparam int unsigned REQ_IDX_W    = idx_w(NREQ_DEFAULT);

endpackage

// File: rtl/heap_array_allocator_rr_arbiter.sv
// Round-robin arbiter: first valid requester at or after the pointer wins.
// The pointer only advances when a grant is actually issued (en_i high).
module rr_arbiter
   import heap_alloc_pkg::*;
#(
   parameter int unsigned NReq = 2,
   parameter int unsigned IW   = idx_w(NReq)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [NReq-1:0] valid_i,
   input  logic            en_i,
   output logic [NReq-1:0] grant_o,
   output logic [IW-1:0]   grant_idx_o,
   output logic            grant_vld_o
);

   logic [IW-1:0] ptr_q, ptr_d;
   logic          found;
   int            c, nxt;

   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      c           = 0;
      nxt         = 0;
      ptr_d       = ptr_q;
      for (int k = 0; k < int'(NReq); k++) begin
         c = int'(ptr_q) + k;
         if (c >= int'(NReq)) c = c - int'(NReq);
         if (!found && valid_i[c]) begin
            found       = 1'b1;
            grant_idx_o = IW'(c);
         end
      end
      grant_vld_o = en_i & found;
      if (grant_vld_o) begin
         grant_o[grant_idx_o] = 1'b1;
         nxt = int'(grant_idx_o) + 1;
         if (nxt >= int'(NReq)) nxt = 0;
         ptr_d = IW'(nxt);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/heap_array_allocator.sv
// Heap array slot allocator: arbitrated alloc/free with a LIFO freed stack,
// in-use bitmap and high-water counter; one operation in flight (3-cycle cadence).
module heap_array_allocator
   import heap_alloc_pkg::*;
#(
   parameter int unsigned MemoryElementWidth = 12,
   parameter int unsigned NArrays            = 20,
   parameter int unsigned NFreedArrays       = 20,
   parameter int unsigned NReq               = 2
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [NReq-1:0]                    req_valid,
   input  logic [NReq-1:0]                    req_free,
   input  logic [NReq*MemoryElementWidth-1:0] req_array,
   output logic [NReq-1:0]                    req_ready,
   output logic                               resp_valid,
   output logic [idx_w(NReq)-1:0]             resp_req,
   output logic [MemoryElementWidth-1:0]      resp_array,
   output logic                               resp_error,
   output logic                               size_clear_valid,
   output logic [MemoryElementWidth-1:0]      size_clear_index,
   output logic [MemoryElementWidth-1:0]      allocs,
   output logic [MemoryElementWidth-1:0]      freed_top
);

   localparam int unsigned MW = MemoryElementWidth;
   localparam int unsigned RW = idx_w(NReq);
   localparam int unsigned AW = idx_w(NArrays);
   localparam int unsigned SW = idx_w(NFreedArrays);
   localparam logic [MW-1:0] NA_W = MW'(NArrays);
   localparam logic [MW-1:0] NF_W = MW'(NFreedArrays);

   state_e          state_q, state_d;
   logic            op_q;
   logic [MW-1:0]   id_q, allocs_q, freed_top_q, resp_array_q, top_m1, exec_id;
   logic [RW-1:0]   rq_q, gnt_idx;
   logic            resp_err_q, gnt_vld, alloc_ok, free_ok;
   logic [NArrays-1:0]  in_use_q;
   logic [MW-1:0]   stack_q [NFreedArrays];

   rr_arbiter #(.NReq(NReq), .IW(RW)) u_arb (
      .clock       (clock),
      .reset       (reset),
      .valid_i     (req_valid),
      .en_i        (state_q == IDLE),
      .grant_o     (req_ready),
      .grant_idx_o (gnt_idx),
      .grant_vld_o (gnt_vld)
   );

   always_comb begin
      state_d  = state_q;
      alloc_ok = 1'b0;
      free_ok  = 1'b0;
      exec_id  = '0;
      top_m1   = freed_top_q - MW'(1);
      unique case (state_q)
         IDLE: if (gnt_vld) state_d = EXEC;
         EXEC: begin
            state_d = RESP;
            if (op_q == OP_ALLOC) begin
               if (freed_top_q != '0) begin
                  alloc_ok = 1'b1;
                  exec_id  = stack_q[top_m1[SW-1:0]];
               end else if (allocs_q < NA_W) begin
                  alloc_ok = 1'b1;
                  exec_id  = allocs_q;
               end
            end else begin
               // id range is checked before the bitmap lookup to keep the index in bounds
               free_ok = (id_q < allocs_q) && (id_q < NA_W) &&
                         (freed_top_q < NF_W) && in_use_q[id_q[AW-1:0]];
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         op_q         <= OP_ALLOC;
         id_q         <= '0;
         rq_q         <= '0;
         allocs_q     <= '0;
         freed_top_q  <= '0;
         in_use_q     <= '0;
         resp_array_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (gnt_vld) begin
            op_q <= req_free[gnt_idx];
            id_q <= req_array[gnt_idx*MW +: MW];
            rq_q <= gnt_idx;
         end
         if (state_q == EXEC) begin
            resp_err_q   <= !(alloc_ok || free_ok);
            resp_array_q <= (op_q == OP_ALLOC) ? exec_id : id_q;
            if (alloc_ok) begin
               in_use_q[exec_id[AW-1:0]] <= 1'b1;
               if (freed_top_q != '0) freed_top_q <= top_m1;
               else                   allocs_q    <= allocs_q + MW'(1);
            end
            if (free_ok) begin
               in_use_q[id_q[AW-1:0]] <= 1'b0;
               freed_top_q <= freed_top_q + MW'(1);
            end
         end
      end
   end

   // Stack contents are only meaningful below freed_top, so they need no reset
   always_ff @(posedge clock) begin
      if (!reset && free_ok) stack_q[freed_top_q[SW-1:0]] <= id_q;
   end

   assign resp_valid       = (state_q == RESP);
   assign resp_req         = resp_valid ? rq_q : '0;
   assign resp_array       = resp_valid ? resp_array_q : '0;
   assign resp_error       = resp_valid & resp_err_q;
   assign size_clear_valid = alloc_ok;
   assign size_clear_index = alloc_ok ? exec_id : '0;
   assign allocs           = allocs_q;
   assign freed_top        = freed_top_q;

endmodule

// File: tb/tb_heap_array_allocator.sv
// Scoreboard bench: drivers push expected responses/clears, a negedge monitor
// pops and compares them, including cycle-exact latency.
module tb_heap_array_allocator;

   localparam int MW = 12;
   localparam int NR = 2;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [NR-1:0]   req_valid = '0;
   logic [NR-1:0]   req_free  = '0;
   logic [NR*MW-1:0] req_array = '0;
   logic [NR-1:0]   req_ready;
   logic            resp_valid, resp_error, size_clear_valid;
   logic [0:0]      resp_req;
   logic [MW-1:0]   resp_array, size_clear_index, allocs, freed_top;

   heap_array_allocator #(
      .MemoryElementWidth(MW), .NArrays(4), .NFreedArrays(4), .NReq(NR)
   ) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_free(req_free), .req_array(req_array),
      .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_req(resp_req), .resp_array(resp_array),
      .resp_error(resp_error),
      .size_clear_valid(size_clear_valid), .size_clear_index(size_clear_index),
      .allocs(allocs), .freed_top(freed_top)
   );

   always #5 clock = ~clock;

   typedef struct { int cyc; int rq; int arr; int err; } rsp_t;
   typedef struct { int cyc; int id; } clr_t;
   rsp_t rsp_q[$];
   clr_t clr_q[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every output pulse must match the oldest pending expectation
   always @(negedge clock) begin
      if (resp_valid) begin
         if (rsp_q.size() == 0) chk("unexpected_resp", 1, 0);
         else begin
            rsp_t e;
            e = rsp_q.pop_front();
            chk("resp_cycle", cyc, e.cyc);
            chk("resp_req", int'(resp_req), e.rq);
            chk("resp_array", int'(resp_array), e.arr);
            chk("resp_error", int'(resp_error), e.err);
         end
      end
      if (size_clear_valid) begin
         if (clr_q.size() == 0) chk("unexpected_size_clear", 1, 0);
         else begin
            clr_t c;
            c = clr_q.pop_front();
            chk("clear_cycle", cyc, c.cyc);
            chk("clear_index", int'(size_clear_index), c.id);
         end
      end
   end

   task automatic push_exp(input int gcyc, input int r, input int arr, input int err, input int clr);
      rsp_t e;
      clr_t c;
      e.cyc = gcyc + 2; e.rq = r; e.arr = arr; e.err = err;
      rsp_q.push_back(e);
      if (clr >= 0) begin
         c.cyc = gcyc + 1; c.id = clr;
         clr_q.push_back(c);
      end
   endtask

   // clr < 0 means no size_clear pulse is expected
   task automatic do_op(input int r, input bit fr, input int id,
                        input int exp_arr, input int exp_err, input int clr);
      int n = 0;
      bit got = 0;
      @(negedge clock);
      req_valid[r] = 1'b1;
      req_free[r]  = fr;
      req_array[r*MW +: MW] = MW'(id);
      while (!got && n < 50) begin
         #1;
         if (req_ready[r]) got = 1;
         else begin @(negedge clock); n++; end
      end
      if (got) push_exp(cyc, r, exp_arr, exp_err, clr);
      else chk("grant_timeout", 0, 1);
      @(negedge clock);
      req_valid[r] = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((rsp_q.size() != 0 || clr_q.size() != 0) && n < 30) begin
         @(negedge clock); #2; n++;
      end
      chk("drain_pending", rsp_q.size() + clr_q.size(), 0);
   endtask

   task automatic pulse_reset();
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      int exp_r, ng, n;
      repeat (3) @(negedge clock);
      chk("rst_allocs", int'(allocs), 0);
      chk("rst_freed_top", int'(freed_top), 0);
      chk("rst_resp_valid", int'(resp_valid), 0);
      chk("rst_clear", int'(size_clear_valid), 0);
      reset = 1'b0;

      // sequential allocation from a fresh heap
      do_op(0, 0, 0, 0, 0, 0);
      do_op(0, 0, 0, 1, 0, 1);
      do_op(0, 0, 0, 2, 0, 2);
      drain();
      chk("allocs_after_3", int'(allocs), 3);

      // free 0, then illegal frees leave state untouched
      do_op(0, 1, 0, 0, 0, -1);
      drain();
      chk("ft_after_free0", int'(freed_top), 1);
      do_op(0, 1, 0, 0, 1, -1);
      do_op(0, 1, 7, 7, 1, -1);
      do_op(0, 1, 25, 25, 1, -1);
      drain();
      chk("allocs_after_err", int'(allocs), 3);
      chk("ft_after_err", int'(freed_top), 1);
      do_op(0, 0, 0, 0, 0, 0);
      drain();
      chk("ft_after_realloc0", int'(freed_top), 0);

      // LIFO reuse
      do_op(0, 1, 1, 1, 0, -1);
      do_op(0, 1, 2, 2, 0, -1);
      drain();
      chk("ft_2", int'(freed_top), 2);
      do_op(0, 0, 0, 2, 0, 2);
      drain();
      chk("ft_1", int'(freed_top), 1);
      do_op(0, 0, 0, 1, 0, 1);
      drain();
      chk("ft_0", int'(freed_top), 0);
      do_op(0, 0, 0, 3, 0, 3);
      drain();
      chk("allocs_full", int'(allocs), 4);

      // heap exhausted, requested by requester 1 (pointer returns to 0)
      do_op(1, 0, 0, 0, 1, -1);
      drain();
      chk("allocs_still_full", int'(allocs), 4);

      // both requesters hold requests: grants must alternate
      @(negedge clock);
      req_free  = '0;
      req_valid = 2'b11;
      exp_r = 0; ng = 0; n = 0;
      while (ng < 4 && n < 60) begin
         #1;
         if (req_ready != '0) begin
            chk("grant_onehot", $countones(req_ready), 1);
            chk("rr_order", req_ready[1] ? 1 : 0, exp_r);
            push_exp(cyc, req_ready[1] ? 1 : 0, 0, 1, -1);
            exp_r = 1 - exp_r;
            ng++;
         end
         @(negedge clock);
         n++;
      end
      req_valid = '0;
      chk("rr_grants", ng, 4);
      drain();

      pulse_reset();
      #2;
      chk("rst2_allocs", int'(allocs), 0);
      chk("rst2_freed_top", int'(freed_top), 0);

      // reset during EXEC: size_clear still pulses that cycle, no response follows
      @(negedge clock);
      req_valid[0] = 1'b1;
      req_free[0]  = 1'b0;
      n = 0;
      while (n < 20) begin
         #1;
         if (req_ready[0]) break;
         @(negedge clock); n++;
      end
      chk("midrst_grant", int'(req_ready[0]), 1);
      begin
         clr_t c;
         c.cyc = cyc + 1; c.id = 0;
         clr_q.push_back(c);
      end
      @(negedge clock);
      #2;
      reset = 1'b1;
      req_valid = '0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (4) @(negedge clock);
      #2;
      chk("midrst_allocs", int'(allocs), 0);
      chk("midrst_pending_clear", clr_q.size(), 0);
      do_op(0, 0, 0, 0, 0, 0);
      drain();
      chk("post_rst_allocs", int'(allocs), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/heap_array_allocator.md
Name: heap_array_allocator

Overview:
- Controller that owns allocation and freeing of heap array slots for the zero machine.
- Arbitrates alloc/free requests from NReq requesters (e.g. instruction sequencer, debug/loader port) with round-robin fairness.
- Maintains the high-water allocation count (allocs), the freed-arrays LIFO stack and an in-use bitmap.
- Emits a size-clear command so the arraySizes entry of a newly allocated array is zeroed.

Parameters:
- MemoryElementWidth, 12, width of array ids and counters
- NArrays, 20, maximum number of arrays; ids are 0..NArrays-1
- NFreedArrays, 20, depth of the freed-arrays stack
- NReq, 2, number of requesters (>=1)

Ports:
- clock  in  1  single clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  NReq  request pending per requester; held until granted
- req_free  in  NReq  per requester: 1 = free, 0 = alloc
- req_array  in  NReq*MemoryElementWidth  array id to free (ignored for alloc)
- req_ready  out  NReq  one-hot, one-cycle grant pulse; request captured this cycle
- resp_valid  out  1  one-cycle completion pulse
- resp_req  out  $clog2(NReq) (min 1)  index of requester being answered
- resp_array  out  MemoryElementWidth  allocated id (alloc) or echoed id (free)
- resp_error  out  1  operation failed; no state changed
- size_clear_valid  out  1  pulse: zero arraySizes[size_clear_index]
- size_clear_index  out  MemoryElementWidth  array id to clear
- allocs  out  MemoryElementWidth  number of ids ever handed out (high-water mark)
- freed_top  out  MemoryElementWidth  current freed-stack depth

Behaviour:
- Reset (synchronous, active-high): FSM=IDLE; allocs=0; freed_top=0; in_use all 0; rr pointer=0; all outputs 0. Reset mid-operation discards the in-flight request with no response.
- FSM states are IDLE -> EXEC -> RESP -> IDLE. Exactly one operation is in flight.
- IDLE:
  - If any req_valid, pick the first valid requester at or after the rr pointer (wrapping).
  - Pulse req_ready for that requester only; capture op, id and requester index; go to EXEC.
  - rr pointer = granted index + 1 mod NReq.
  - With no request, remain in IDLE.
- EXEC, alloc:
  - If freed_top>0: id = stack[freed_top-1]; freed_top-1.
  - Else if allocs<NArrays: id = allocs; allocs+1.
  - Else: error, id=0.
  - On success set in_use[id] and pulse size_clear_valid/size_clear_index=id in this cycle.
- EXEC, free:
  - Error if id>=allocs or !in_use[id] (double free).
  - freed_top==NFreedArrays cannot occur when in_use is consistent; treat it as an error anyway.
  - Otherwise stack[freed_top]=id; freed_top+1; clear in_use[id].
- RESP: resp_valid=1 with resp_req, resp_array, resp_error stable for this one cycle. No grant in RESP. Return to IDLE.
- Latency: grant at cycle N, size_clear at N+1, resp_valid at N+2. Peak throughput is one operation per 3 cycles.
- LIFO order: most recently freed id is reused first. allocs never decreases.
- A requester keeps req_valid asserted and its fields stable until req_ready. A deasserted request is simply not considered.
- Error responses leave allocs, freed_top, in_use and the stack unchanged.
- Arithmetic: counters are MemoryElementWidth bits. Comparisons are unsigned. Ids >= NArrays on free are errors, with no out-of-range indexing.

Decomposition:
- Package heap_alloc_pkg holds:
  - state enum {IDLE, EXEC, RESP}
  - op encoding (OP_ALLOC=0, OP_FREE=1)
  - localparam for the requester-index width
- One sub-module, rr_arbiter (NReq requesters; inputs valid vector and enable; outputs one-hot grant, grant index, pointer update).
- The freed stack and in_use bitmap stay inline.

Test Plan:
- Reset, then requester 0 allocs 3 times -> resp_array 0,1,2; size_clear_index 0,1,2; allocs=3; resp_valid exactly 2 cycles after each req_ready.
- Free 1, then free 2, then alloc -> returns 2 (LIFO), then alloc -> 1, then alloc -> 3; freed_top 2,1,0.
- Double free of id 0, free of id 7 while allocs=3, free of id 25 -> resp_error=1 each time; allocs, freed_top and in_use unchanged.
- NArrays=4: allocate 4 times, then a 5th alloc -> resp_error=1, resp_array=0, no size_clear pulse.
- Both requesters hold req_valid continuously -> grants alternate 0,1,0,1; resp_req matches; no request is starved.
- Assert reset in the EXEC cycle of an alloc -> no resp_valid, allocs=0; next alloc returns id 0.
